// File: rtl/ifu_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_if
// Description : Bus bundle between the instruction-fetch unit, the instruction
//               ROM read port and the decode stage. Signal suffixes are named
//               from the fetch unit's point of view. The master modport is
//               for the fetch unit and the slave modport is for its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface ifu_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // ROM read port
  logic                  ce_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] data_i;
  // Control from the back end
  logic                  redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_pc_i;
  logic                  halt_i;
  // Decode handshake
  logic                  inst_valid_o;
  logic [DATA_WIDTH-1:0] inst_o;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic                  inst_ready_i;

  modport master (
    output ce_o, addr_o,
    input  data_i,
    input  redirect_i, redirect_pc_i, halt_i,
    output inst_valid_o, inst_o, pc_o,
    input  inst_ready_i
  );

  modport slave (
    input  ce_o, addr_o,
    output data_i,
    output redirect_i, redirect_pc_i, halt_i,
    input  inst_valid_o, inst_o, pc_o,
    output inst_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Instruction-fetch initiator. It reads the ROM at the current
//               PC and buffers {pc, word} pairs in a small FIFO. It presents
//               the FIFO head to decode over valid/ready. It handles PC
//               redirect with flush, and a level-sensitive halt.
//               Optional feature macro IFU_PERF_EN adds 64-bit fetch and
//               stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h8000_0000),
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master bus
`ifdef IFU_PERF_EN
  ,
  output logic [63:0] fetch_cnt_o,
  output logic [63:0] stall_cnt_o
`endif
);

  localparam int               c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int               c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [c_CNT_W-1:0]    count_q, count_d;
  logic [c_PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] pc_mem_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] inst_mem_q [FIFO_DEPTH];

  logic                  w_not_empty;
  logic                  w_ce;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_redirect_pc;
  logic                  w_unused_pc_lsb;

  // The target's byte offset is dropped, so it is intentionally left unread.
  assign w_unused_pc_lsb = ^bus.redirect_pc_i[1:0];
  assign w_redirect_pc   = {bus.redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};

  assign w_not_empty = (count_q != '0);
  // Fetch depends only on registered occupancy. A full FIFO does not refetch
  // on a same-cycle pop, which keeps inst_ready_i off the ROM enable path.
  assign w_ce  = (state_q == ST_FETCH) && (count_q < c_DEPTH) &&
                 !bus.redirect_i && !bus.halt_i;
  // A redirect flushes the FIFO, so the pop that would happen with it is discarded.
  assign w_pop = w_not_empty && bus.inst_ready_i && !bus.redirect_i;

  assign bus.ce_o         = w_ce;
  assign bus.addr_o       = pc_q;
  assign bus.inst_valid_o = w_not_empty;
  assign bus.inst_o       = w_not_empty ? inst_mem_q[rd_ptr_q] : '0;
  assign bus.pc_o         = w_not_empty ? pc_mem_q[rd_ptr_q]   : '0;

  // Next-state computation: redirect overrides normal push/pop bookkeeping.
  always_comb begin
    state_d  = bus.halt_i ? ST_HALT : ST_FETCH;
    pc_d     = pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (bus.redirect_i) begin
      pc_d     = w_redirect_pc;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (w_ce) begin
        pc_d     = pc_q + ADDR_WIDTH'(4);
        wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
      end
      if (w_ce && !w_pop) begin
        count_d = count_q + c_CNT_W'(1);
      end else if (!w_ce && w_pop) begin
        count_d = count_q - c_CNT_W'(1);
      end
    end
  end

  // Control state, PC and FIFO pointers. BOOT is one cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage captures the same-cycle ROM data. It is not reset because
  // the outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (!rst && w_ce) begin
      pc_mem_q[wr_ptr_q]   <= pc_q;
      inst_mem_q[wr_ptr_q] <= bus.data_i;
    end
  end

`ifdef IFU_PERF_EN
  logic [63:0] fetch_cnt_q;
  logic [63:0] stall_cnt_q;

  // Performance counters are cleared only by reset and wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (w_ce) begin
        fetch_cnt_q <= fetch_cnt_q + 64'd1;
      end
      if ((state_q == ST_FETCH) && (count_q == c_DEPTH)) begin
        stall_cnt_q <= stall_cnt_q + 64'd1;
      end
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Scoreboard bench for ifu_fetch. A reference model predicts
//               fetches from the fetch rules and queues the expected
//               {pc, word} entries. A separate monitor checks and retires
//               them at the decode handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;
  localparam int          AW         = 32;
  localparam int          DW         = 32;
  localparam int          DEPTH      = 2;
  localparam logic [31:0] c_RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst;

  ifu_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef IFU_PERF_EN
  logic [63:0] fetch_cnt;
  logic [63:0] stall_cnt;
`endif

  ifu_fetch #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (c_RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef IFU_PERF_EN
    ,
    .fetch_cnt_o (fetch_cnt),
    .stall_cnt_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // The ROM contents are word = address + 0x13.
  assign bus.data_i = bus.addr_o + 32'h13;

  int checks = 0;
  int errors = 0;

  // Model state: the expected buffer, the PC, and the boot and halted conditions.
  ent_t        exp_q[$];
  logic [31:0] m_pc     = c_RESET_PC;
  bit          m_boot   = 1'b1;
  bit          m_halted = 1'b0;
  logic [63:0] m_fetch  = '0;
  logic [63:0] m_stall  = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: predict the fetch decision mid-cycle, and apply the edge effects late in the cycle.
  initial begin
    bit exp_ce;
    bit stall_now;
    forever begin
      @(posedge clk);
      #3;
      exp_ce    = !rst && !m_boot && !m_halted && !bus.halt_i && !bus.redirect_i &&
                  (exp_q.size() < DEPTH);
      stall_now = !rst && !m_boot && !m_halted && (exp_q.size() == DEPTH);
      if (!rst) begin
        chk("ce_o", 64'(bus.ce_o), 64'(exp_ce));
        chk("addr_o", 64'(bus.addr_o), 64'(m_pc));
`ifdef IFU_PERF_EN
        chk("fetch_cnt_o", fetch_cnt, m_fetch);
        chk("stall_cnt_o", stall_cnt, m_stall);
`endif
      end
      #4;
      if (rst) begin
        exp_q.delete();
        m_pc     = c_RESET_PC;
        m_boot   = 1'b1;
        m_halted = 1'b0;
        m_fetch  = '0;
        m_stall  = '0;
      end else begin
        if (bus.redirect_i) begin
          exp_q.delete();
          m_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
        end else if (exp_ce) begin
          exp_q.push_back('{pc: m_pc, inst: m_pc + 32'h13});
          m_pc = m_pc + 32'd4;
        end
        if (exp_ce)    m_fetch = m_fetch + 64'd1;
        if (stall_now) m_stall = m_stall + 64'd1;
        m_boot   = 1'b0;
        m_halted = bus.halt_i;
      end
    end
  end

  // Monitor: compare the DUT head with the scoreboard head, and retire it on an accepted handshake.
  initial begin
    bit   exp_valid;
    ent_t head;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_valid = (exp_q.size() != 0);
        chk("inst_valid_o", 64'(bus.inst_valid_o), 64'(exp_valid));
        if (exp_valid) begin
          head = exp_q[0];
          chk("pc_o", 64'(bus.pc_o), 64'(head.pc));
          chk("inst_o", 64'(bus.inst_o), 64'(head.inst));
          if (bus.inst_ready_i && !bus.redirect_i) begin
            void'(exp_q.pop_front());
          end
        end else begin
          chk("pc_o_idle", 64'(bus.pc_o), 64'd0);
          chk("inst_o_idle", 64'(bus.inst_o), 64'd0);
        end
      end
    end
  end

  task automatic step(input bit r, input bit rdy, input bit h, input bit rd,
                      input logic [31:0] tgt, input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rst               = r;
      bus.inst_ready_i  = rdy;
      bus.halt_i        = h;
      bus.redirect_i    = rd;
      bus.redirect_pc_i = tgt;
    end
  endtask

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    logic [31:0] tgt;
    rst               = 1'b1;
    bus.inst_ready_i  = 1'b1;
    bus.halt_i        = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;

    step(1, 1, 0, 0, 32'h0, 3);
    step(0, 1, 0, 0, 32'h0, 8);                  // boot, then streaming
    step(0, 0, 0, 0, 32'h0, 5);                  // backpressure fills the FIFO
    step(0, 1, 0, 0, 32'h0, 4);
    step(0, 0, 0, 0, 32'h0, 3);                  // two entries buffered
    step(0, 1, 0, 1, 32'h8000_1003, 1);          // redirect with flush
    step(0, 1, 0, 0, 32'h0, 5);
    step(0, 1, 1, 0, 32'h0, 4);                  // halt while draining
    step(0, 1, 0, 0, 32'h0, 5);
    step(0, 1, 0, 1, 32'hFFFF_FFF6, 1);          // walk across the top of memory
    step(0, 1, 0, 0, 32'h0, 5);
    step(0, 1, 1, 1, 32'h1234_5678, 1);          // redirect and halt together
    step(0, 1, 1, 0, 32'h0, 2);
    step(0, 1, 0, 0, 32'h0, 4);
    step(0, 0, 0, 0, 32'h0, 1);                  // one entry held
    step(1, 0, 0, 1, 32'h0000_4000, 1);          // reset beats the pending redirect
    step(0, 1, 0, 0, 32'h0, 6);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           tgt = $urandom;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 19) == 0), tgt, 1);
    end

    step(0, 1, 0, 0, 32'h0, 6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
